arm_uart_tx: RTL



---
 rtl/arm_uart_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/arm_uart_tx.sv
// arm_uart_tx: 8N1 LSB-first UART transmitter fed through a FIFO, bit period CLK_FREQ/BAUD.
// Build with ARM_UART_TX_PARITY_EN defined to insert an even-parity bit before the stop bit.
module arm_uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef ARM_UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    if (DIV < 2) begin : g_div_check
        $error("arm_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("arm_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          rdy_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
`ifdef ARM_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif
    logic          push, pop, empty, tick;
    logic [7:0]    rd_dat;

    assign push   = in_valid & rdy_q;
    assign empty  = (count_q == '0);
    assign tick   = (cnt_q == DIV_LAST);
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
`ifdef ARM_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rd_dat;
                    state_d = ST_START;
                    txd_d   = 1'b0;
`ifdef ARM_UART_TX_PARITY_EN
                    par_d   = ^rd_dat;
`endif
                end
            end
            ST_START: if (tick) begin
                state_d = ST_DATA;
                bit_d   = '0;
                txd_d   = shift_q[0];
            end
            ST_DATA: if (tick) begin
                if (bit_q == 3'd7) begin
`ifdef ARM_UART_TX_PARITY_EN
                    state_d = ST_PARITY;
                    txd_d   = par_q;
`else
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
`endif
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    txd_d   = shift_q[1];
                end
            end
`ifdef ARM_UART_TX_PARITY_EN
            ST_PARITY: if (tick) begin
                state_d = ST_STOP;
                txd_d   = 1'b1;
            end
`endif
            ST_STOP: if (tick) begin
                // Back-to-back frames: a queued byte starts its start bit with no idle gap.
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rd_dat;
                    state_d = ST_START;
                    txd_d   = 1'b0;
`ifdef ARM_UART_TX_PARITY_EN
                    par_d   = ^rd_dat;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
`ifdef ARM_UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            rdy_q   <= (count_d != FULL_CNT);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef ARM_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign in_ready   = rdy_q;
    assign txd        = txd_q;
    assign busy       = !empty || (state_q != ST_IDLE);
    assign fifo_count = count_q;
endmodule
